// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory stage: turns EX/MEM control into req/ack data-memory accesses
// Double-word accesses are split into two word accesses; the result is registered for MEM/WB.
module mem_access_unit #(
  parameter bit BYTE_SIGNED = 1'b1,
  parameter int DW_STRIDE   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iFlush,
  input  logic        iByte,
  input  logic        iWrite,
  input  logic        iFloat,
  input  logic        iMWrite,
  input  logic        iDW,
  input  logic [1:0]  iWBsrc,
  input  logic [31:0] iALUout1,
  input  logic [31:0] iRegOut1,
  input  logic [31:0] iRegOut2,
  input  logic [31:0] iPcp4,
  input  logic [4:0]  iDstReg,
  output logic        oStall,
  output logic        oMemReq,
  output logic        oMemWe,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemWdata,
  output logic [3:0]  oMemBe,
  input  logic        iMemAck,
  input  logic [31:0] iMemRdata,
  output logic        oWrite,
  output logic        oFloat,
  output logic        oDW,
  output logic [1:0]  oWBsrc,
  output logic [4:0]  oDstReg,
  output logic [31:0] oALUout1,
  output logic [31:0] oPcp4,
  output logic [31:0] oMemLo,
  output logic [31:0] oMemHi
);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2} state_t;

  localparam logic [31:0] STRIDE = 32'(DW_STRIDE);

  state_t      state;
  logic [31:0] lo_buf;
  logic        memop;
  logic        byte_acc;
  logic        is_load;
  logic        final_ack;
  logic        capture;
  logic [31:0] word_addr;
  logic [31:0] rdata_shift;
  logic [7:0]  lane;
  logic [31:0] byte_data;

  assign memop     = !iFlush && (iMWrite || iWBsrc == 2'b01);
  assign byte_acc  = iByte && !iDW;
  assign is_load   = !iMWrite;
  assign word_addr = {iALUout1[31:2], 2'b00};

  // Little-endian lane select: lane 0 is rdata[7:0].
  assign rdata_shift = iMemRdata >> {iALUout1[1:0], 3'b000};
  assign lane        = rdata_shift[7:0];
  assign byte_data   = BYTE_SIGNED ? {{24{lane[7]}}, lane} : {24'h000000, lane};

  assign final_ack = ((state == ACC1) && iMemAck && !iDW) || ((state == ACC2) && iMemAck);
  assign capture   = ((state == IDLE) && !memop) || final_ack;

  // Request side is combinational from state and the held EX/MEM inputs; reset forces it quiet.
  always_comb begin
    oStall    = 1'b0;
    oMemReq   = 1'b0;
    oMemWe    = 1'b0;
    oMemAddr  = 32'h0;
    oMemWdata = 32'h0;
    oMemBe    = 4'h0;
    if (rst_n) begin
      case (state)
        IDLE: oStall = memop;
        ACC1: begin
          oMemReq  = 1'b1;
          oMemWe   = iMWrite;
          oMemAddr = byte_acc ? iALUout1 : word_addr;
          oMemBe   = byte_acc ? (4'b0001 << iALUout1[1:0]) : 4'b1111;
          if (iMWrite) oMemWdata = byte_acc ? {4{iRegOut2[7:0]}} : iRegOut2;
          oStall   = !final_ack;
        end
        ACC2: begin
          oMemReq  = 1'b1;
          oMemWe   = iMWrite;
          oMemAddr = word_addr + STRIDE;
          oMemBe   = 4'b1111;
          if (iMWrite) oMemWdata = iRegOut1;
          oStall   = !iMemAck;
        end
        default: oStall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lo_buf   <= 32'h0;
      oWrite   <= 1'b0;
      oFloat   <= 1'b0;
      oDW      <= 1'b0;
      oWBsrc   <= 2'b00;
      oDstReg  <= 5'd0;
      oALUout1 <= 32'h0;
      oPcp4    <= 32'h0;
      oMemLo   <= 32'h0;
      oMemHi   <= 32'h0;
    end else begin
      if (capture) begin
        oWrite   <= iWrite && !iFlush;
        oFloat   <= iFloat;
        oDW      <= iDW;
        oWBsrc   <= iWBsrc;
        oDstReg  <= iDstReg;
        oALUout1 <= iALUout1;
        oPcp4    <= iPcp4;
      end
      case (state)
        IDLE: if (memop) state <= ACC1;
        ACC1: begin
          if (iMemAck) begin
            if (iDW) begin
              lo_buf <= iMemRdata;
              state  <= ACC2;
            end else begin
              state  <= IDLE;
              oMemLo <= is_load ? (byte_acc ? byte_data : iMemRdata) : 32'h0;
              oMemHi <= 32'h0;
            end
          end
        end
        ACC2: begin
          if (iMemAck) begin
            state  <= IDLE;
            oMemLo <= is_load ? lo_buf : 32'h0;
            oMemHi <= is_load ? iMemRdata : 32'h0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
